// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient to LO (q), remainder to HI (r), sign fix-up in a final cycle.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   // Operand context captured on the accept edge
   typedef struct packed {
      logic             sgn;
      logic             neg_a;
      logic             neg_b;
      logic [WIDTH-1:0] orig;
      logic [WIDTH-1:0] mag_b;
   } op_t;

   state_t           state, state_nx;
   op_t              op;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   rem_sh;
   logic             ge;
   logic [WIDTH-1:0] q_fix, r_fix;

   assign abs_a = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
   assign abs_b = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

   // One restoring step: shift next dividend bit into the partial remainder
   assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
   assign ge     = (rem_sh >= {1'b0, op.mag_b});

   assign q_fix = (op.sgn && (op.neg_a != op.neg_b)) ? -quo : quo;
   assign r_fix = (op.sgn && op.neg_a) ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = CALC;
         CALC: if (cnt == CW'(WIDTH-1)) state_nx = FIX;
         FIX:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op          <= '0;
         rem         <= '0;
         quo         <= '0;
         cnt         <= '0;
         q           <= '0;
         r           <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op.sgn   <= sign;
                  op.neg_a <= sign & dividend[WIDTH-1];
                  op.neg_b <= sign & divisor[WIDTH-1];
                  op.orig  <= dividend;
                  op.mag_b <= abs_b;
                  quo      <= abs_a;
                  rem      <= '0;
                  cnt      <= '0;
               end
            end
            CALC: begin
               rem <= ge ? (rem_sh - {1'b0, op.mag_b}) : rem_sh;
               quo <= {quo[WIDTH-2:0], ge};
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               done <= 1'b1;
               if (op.mag_b == '0) begin
                  q           <= '1;
                  r           <= op.orig;
                  div_by_zero <= 1'b1;
               end else begin
                  q           <= q_fix;
                  r           <= r_fix;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, busy width, sign cases,
// boundaries, divide-by-zero, start handshake and mid-operation reset.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sign;
   logic [31:0] dividend, divisor;
   logic [31:0] q, r;
   logic        busy, done, div_by_zero;

   int checks   = 0;
   int failures = 0;

   div_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .sign(sign),
      .dividend(dividend), .divisor(divisor),
      .q(q), .r(r), .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at a negedge; issues start there and follows the op to done.
   // interfere: pulse start with other operands at edges 5 and 20.
   task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic ez,
                          input bit interfere);
      int edges;
      int busy_cnt;
      start = 1'b1; sign = s; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0;
      edges = 0; busy_cnt = 0;
      while (!done && edges < 40) begin
         if (busy) busy_cnt++;
         if (interfere && (edges == 5 || edges == 20)) begin
            start = 1'b1; sign = 1'b1; dividend = 32'd1000; divisor = 32'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         edges++;
      end
      start = 1'b0;
      check({tag, " latency"}, 32'(edges), 32'd33);
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
      check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
      check({tag, " q"}, q, eq);
      check({tag, " r"}, r, er);
      check({tag, " dz"}, {31'd0, div_by_zero}, {31'd0, ez});
   endtask

   initial begin
      int edges;
      int seen_done;
      rst = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
      @(negedge clk); @(negedge clk);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst q", q, 32'd0);
      check("rst r", r, 32'd0);
      check("rst dz", {31'd0, div_by_zero}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("q_hold", q, 32'd14);
      check("r_hold", r, 32'd2);

      run_div("s-7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_div("s7_-2",  1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0);
      run_div("s-7_-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 1'b0);
      run_div("u_f9_2", 1'b0, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 32'd1,         1'b0, 1'b0);

      run_div("s_ovf",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
      run_div("u_max",  1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
      run_div("u5_9",   1'b0, 32'd5,         32'd9,          32'd0,         32'd5, 1'b0, 1'b0);

      run_div("dz_u",   1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
      run_div("dz_s",   1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
      run_div("dz_clr", 1'b0, 32'd10,        32'd5, 32'd2,         32'd0,         1'b0, 1'b0);

      run_div("ignore_start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
      // Still in the done cycle: start again for back-to-back acceptance
      run_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

      // Reset at cycle 17 of a division
      @(negedge clk);
      start = 1'b1; sign = 1'b0; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 17; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst busy", {31'd0, busy}, 32'd0);
      check("mid_rst done", {31'd0, done}, 32'd0);
      check("mid_rst q", q, 32'd0);
      check("mid_rst r", r, 32'd0);
      check("mid_rst dz", {31'd0, div_by_zero}, 32'd0);
      seen_done = 0;
      edges = 0;
      while (edges < 40) begin
         @(negedge clk);
         if (done) seen_done++;
         edges++;
      end
      check("mid_rst no_done", 32'(seen_done), 32'd0);

      run_div("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle 32-bit integer divider for the CPU's DIV/DIVU instructions, the inverse of the combinational multiplier in the HI/LO datapath.
- Uses a radix-2 restoring algorithm that produces one quotient bit per clock.
- Quotient goes to LO and remainder goes to HI. The control unit stalls the PC while busy is high.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (only 32 is verified)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only while idle
sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start
dividend  input  WIDTH  numerator; captured with start
divisor  input  WIDTH  denominator; captured with start
q  output  WIDTH  quotient (to LO)
r  output  WIDTH  remainder (to HI)
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; q/r/div_by_zero valid from this cycle
div_by_zero  output  1  set with done when captured divisor == 0

Behaviour:
- Reset: synchronous, active-high, takes priority over everything.
  - Next state IDLE.
  - q, r, busy, done, div_by_zero all 0; iteration counter 0.
  - Reset mid-operation aborts the division with no done pulse.
- States: IDLE, CALC, FIX.
- Accept edge (E0): rising edge with state == IDLE and start == 1.
  - Register sign, the sign bits of both operands, and the magnitudes |dividend| and |divisor| (two's-complement negate when sign==1 and the MSB is set; otherwise pass through).
  - 0x80000000 has magnitude 0x80000000, treated as an unsigned WIDTH-bit value.
  - Clear the partial remainder (WIDTH+1 bits) and counter; go to CALC; busy=1.
- CALC, edges E1..E32, one iteration per edge:
  - Shift {rem, quo} left one bit, bringing in the next dividend MSB.
  - If rem >= |divisor|, subtract it and set the quotient LSB to 1.
  - Counter increments; at E32 (counter == WIDTH-1) go to FIX.
- FIX, edge E33:
  - If sign==1 and the operand signs differ, q = negated quotient; otherwise q = quotient.
  - If sign==1 and the dividend was negative, r = negated remainder; otherwise r = remainder.
  - Truncation is toward zero.
  - done=1, busy=0, state back to IDLE.
- Latency: done is high in the cycle after E33, which is 33 clocks after the accept edge. busy is high for exactly 33 cycles.
- done is high for exactly one cycle. q, r and div_by_zero hold their values until the next FIX edge or reset.
- Divisor == 0: the division still runs the full latency. At FIX, override to q = all ones (0xFFFFFFFF), r = original dividend (unmodified), div_by_zero = 1. Otherwise div_by_zero = 0 at FIX.
- Signed overflow (0x80000000 / 0xFFFFFFFF, sign=1): q = 0x80000000, r = 0 (natural wrap), div_by_zero = 0.
- Start in other states:
  - start while busy is ignored; captured operands are not disturbed.
  - start in the done cycle (state already IDLE) is accepted, giving back-to-back operation with no dead cycle.
- Operand inputs are don't-care except on the accept edge.
- The single-cycle instruction path never sees intermediate q/r values, because outputs only change at FIX.

Test Plan:
1. Unsigned basic: sign=0, dividend=100, divisor=7, start 1 cycle → done 33 cycles after accept; q=14, r=2; busy high exactly 33 cycles; div_by_zero=0.
2. Signed sign combinations:
   - -7/2 → q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
   - 7/-2 → q=-3, r=1.
   - -7/-2 → q=3, r=-1.
   - Same bits 0xFFFFFFF9/2 with sign=0 → q=0x7FFFFFFC, r=1.
3. Boundaries:
   - sign=1, 0x80000000/0xFFFFFFFF → q=0x80000000, r=0.
   - sign=0, 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
   - 5/9 → q=0, r=5.
4. Divide by zero: dividend=0x12345678, divisor=0, both sign values → after 33 cycles q=0xFFFFFFFF, r=0x12345678, div_by_zero=1. A following 10/5 clears the flag, giving q=2, r=0.
5. Handshake:
   - Pulse start again at cycles 5 and 20 of a 100/7 division with different operands → ignored, result still 14/2.
   - Assert start during the done cycle with 9/3 → accepted, done again 33 cycles later with q=3, r=0.
6. Reset: assert rst at cycle 17 of a division → next cycle busy=0, done=0, q=0, r=0, div_by_zero=0; no done pulse follows. A new 100/7 then completes normally.
